// File: rtl/dvp_frame_streamer_if.sv
// Pixel handshake and DVP video bus shared by the frame streamer and its environment.
// master: upstream buffer / video sink side; slave: the streamer itself.
interface dvp_frame_streamer_if;
  logic [15:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic        vsync;
  logic        href;
  logic [15:0] pixel_out;

  modport master (
    output s_pixel, s_valid,
    input  s_ready, vsync, href, pixel_out
  );

  modport slave (
    input  s_pixel, s_valid,
    output s_ready, vsync, href, pixel_out
  );
endinterface

// File: rtl/dvp_frame_streamer.sv
// DVP-style video source: pulls RGB565 pixels over valid/ready and emits a
// vsync/href/pixel stream with fixed sync, blanking and line timing.
// Optional macro DVP_STALL_EN: a missing pixel stalls the line instead of zero-filling.
module dvp_frame_streamer #(
  parameter int unsigned IMG_WIDTH     = 640,
  parameter int unsigned IMG_HEIGHT    = 480,
  parameter int unsigned VSYNC_CYCLES  = 10,
  parameter int unsigned HBLANK_CYCLES = 5,
  parameter int unsigned VBLANK_CYCLES = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  dvp_frame_streamer_if.slave bus,
  output logic                busy,
  output logic                frame_done,
  output logic                underflow
);

  localparam int unsigned PIX_W   = 16;
  localparam int unsigned COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned BLK_A   = (VSYNC_CYCLES > HBLANK_CYCLES) ? VSYNC_CYCLES : HBLANK_CYCLES;
  localparam int unsigned BLK_MAX = (BLK_A > VBLANK_CYCLES) ? BLK_A : VBLANK_CYCLES;
  localparam int unsigned CNT_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               underflow_q, underflow_d;
  logic               slot_adv;

  // Upstream may hand over a pixel in every ACTIVE slot.
  assign bus.s_ready   = (state_q == ACTIVE);
  assign bus.vsync     = vsync_q;
  assign bus.href      = href_q;
  assign bus.pixel_out = pixel_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign underflow     = underflow_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      pixel_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      pixel_q      <= pixel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
    end
  end

  // Frame sequencing; sync/busy/done are decoded from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    href_d      = 1'b0;
    pixel_d     = '0;
    slot_adv    = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = VSYNC;
          cnt_d       = '0;
          underflow_d = 1'b0;
        end
      end

      VSYNC: begin
        if (cnt_q == CNT_W'(VSYNC_CYCLES - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ACTIVE: begin
        if (bus.s_valid) begin
          href_d  = 1'b1;
          pixel_d = bus.s_pixel;
        end else begin
`ifdef DVP_STALL_EN
          slot_adv = 1'b0;
`else
          href_d      = 1'b1;
          underflow_d = 1'b1;
`endif
        end
        if (slot_adv) begin
          if (col_q == COL_W'(IMG_WIDTH - 1)) begin
            state_d = HBLANK;
            cnt_d   = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      HBLANK: begin
        if (cnt_q == CNT_W'(HBLANK_CYCLES - 1)) begin
          cnt_d = '0;
          if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
            state_d = VBLANK;
          end else begin
            state_d = ACTIVE;
            row_d   = row_q + ROW_W'(1);
            col_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      VBLANK: begin
        if (cnt_q == CNT_W'(VBLANK_CYCLES - 1)) begin
          cnt_d = '0;
          if (continuous) begin
            state_d     = VSYNC;
            underflow_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
      end
    endcase

    vsync_d      = (state_d != VSYNC);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == VBLANK) && (cnt_d == CNT_W'(VBLANK_CYCLES - 1));
  end

endmodule
